f1_race_tally: RTL and testbench



---
 rtl/f1_pkg.sv | 19 +
 rtl/f1_channel_slot.sv | 48 ++++
 rtl/f1_race_tally.sv | 132 +++++++++++++
 tb/tb_f1_race_tally.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and helpers for the f1 race tally
package f1_pkg;

  typedef enum logic [1:0] {
    WARN_NONE       = 2'd0,
    WARN_DUP_ADD    = 2'd1,
    WARN_ABSENT     = 2'd2,
    WARN_FULL_BADCH = 2'd3
  } warn_code_e;

  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_REMOVE = 1'b1;

  // Channel select width; never narrower than one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/f1_channel_slot.sv
// rtl/f1_channel_slot.sv - one channel's presence vector and saturating counter
module f1_channel_slot #(
  parameter int ID_W    = 4,
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear,
  input  logic               set_en,
  input  logic [ID_W-1:0]    set_id,
  input  logic               clr_en,
  input  logic [ID_W-1:0]    clr_id,
  input  logic [ID_W-1:0]    query_id,
  output logic               is_present,
  output logic               is_full,
  output logic [COUNT_W-1:0] count
);

  logic [(2**ID_W)-1:0] pres;
  logic                 do_set;
  logic                 do_clr;

  assign is_present = pres[query_id];
  assign is_full    = (count == '1);

  // Guards repeat the top-level checks so the counter can never wrap on its own.
  assign do_set = set_en && !pres[set_id] && !is_full;
  assign do_clr = clr_en && pres[clr_id];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pres  <= '0;
      count <= '0;
    end else if (clear) begin
      pres  <= '0;
      count <= '0;
    end else begin
      if (do_set) pres[set_id] <= 1'b1;
      if (do_clr) pres[clr_id] <= 1'b0;
      if (do_set && !do_clr) begin
        count <= count + 1'b1;
      end else if (do_clr && !do_set) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/f1_race_tally.sv
// rtl/f1_race_tally.sv - multi-channel car-ID tally with move arbitration, history and warnings
// Define F1_WARN_STICKY_EN to latch the first warning cause until clear or RST.
module f1_race_tally
  import f1_pkg::*;
#(
  parameter int  NUM_CH  = 2,
  parameter int  ID_W    = 4,
  parameter int  COUNT_W = 8,
  parameter int  DEPTH   = 2,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  input  logic                      valid,
  input  logic [ID_W-1:0]           number,
  input  logic [CH_W-1:0]           mode,
  input  logic                      selection,
  output logic [NUM_CH*COUNT_W-1:0] count,
  output logic [COUNT_W+CH_W-1:0]   total,
  output logic [DEPTH*ID_W-1:0]     hist,
  output logic                      warning,
  output logic [1:0]                warn_code
);

  logic [NUM_CH-1:0] hit, full, tgt_oh, other_oh, set_en, clr_en;
  logic              tgt_hit, tgt_full, ch_ok, accept, inc, dec;
  warn_code_e        code;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    f1_channel_slot #(.ID_W(ID_W), .COUNT_W(COUNT_W)) u_slot (
      .CLK        (CLK),
      .RST        (RST),
      .clear      (clear),
      .set_en     (set_en[k]),
      .set_id     (number),
      .clr_en     (clr_en[k]),
      .clr_id     (number),
      .query_id   (number),
      .is_present (hit[k]),
      .is_full    (full[k]),
      .count      (count[k*COUNT_W +: COUNT_W])
    );
  end

  assign ch_ok = (int'(mode) < NUM_CH);

  // Split presence hits into the target channel and the (at most one) other holder.
  always_comb begin
    tgt_hit  = 1'b0;
    tgt_full = 1'b0;
    tgt_oh   = '0;
    other_oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(mode) == k) begin
        tgt_oh[k] = 1'b1;
        tgt_hit   = hit[k];
        tgt_full  = full[k];
      end else begin
        other_oh[k] = hit[k];
      end
    end
  end

  always_comb begin
    code   = WARN_NONE;
    accept = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    set_en = '0;
    clr_en = '0;
    if (valid) begin
      if (!ch_ok) begin
        code = WARN_FULL_BADCH;
      end else if (selection == OP_ADD) begin
        if (tgt_hit) begin
          code = WARN_DUP_ADD;
        end else if (tgt_full) begin
          code = WARN_FULL_BADCH;
        end else begin
          accept = 1'b1;
          set_en = tgt_oh;
          clr_en = other_oh;
          inc    = (other_oh == '0);
        end
      end else if (!tgt_hit) begin
        code = WARN_ABSENT;
      end else begin
        accept = 1'b1;
        clr_en = tgt_oh;
        dec    = 1'b1;
      end
    end
  end

  // A move leaves the total unchanged, so only plain adds and removes adjust it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      total     <= '0;
      hist      <= '0;
      warning   <= 1'b0;
      warn_code <= 2'd0;
    end else if (clear) begin
      total     <= '0;
      hist      <= '0;
      warning   <= 1'b0;
      warn_code <= 2'd0;
    end else begin
      if (inc) begin
        total <= total + 1'b1;
      end else if (dec) begin
        total <= total - 1'b1;
      end
      if (accept) begin
        for (int s = DEPTH - 1; s > 0; s--) begin
          hist[s*ID_W +: ID_W] <= hist[(s-1)*ID_W +: ID_W];
        end
        hist[ID_W-1:0] <= number;
      end
`ifdef F1_WARN_STICKY_EN
      if (!warning) begin
        warning   <= (code != WARN_NONE);
        warn_code <= code;
      end
`else
      warning   <= (code != WARN_NONE);
      warn_code <= code;
`endif
    end
  end

endmodule

// File: tb/tb_f1_race_tally.sv
// tb/tb_f1_race_tally.sv - scoreboard bench for f1_race_tally against a set-based reference model
module tb_f1_race_tally;
  import f1_pkg::*;

  localparam int NUM_CH  = 3;
  localparam int ID_W    = 4;
  localparam int COUNT_W = 2;
  localparam int DEPTH   = 2;
  localparam int CH_W    = ch_width(NUM_CH);
  localparam int NUM_ID  = 1 << ID_W;
  localparam int MAXC    = (1 << COUNT_W) - 1;

  logic                      CLK = 1'b0;
  logic                      RST = 1'b0;
  logic                      clear = 1'b0;
  logic                      valid = 1'b0;
  logic                      selection = 1'b0;
  logic [ID_W-1:0]           number = '0;
  logic [CH_W-1:0]           mode = '0;
  logic [NUM_CH*COUNT_W-1:0] count;
  logic [COUNT_W+CH_W-1:0]   total;
  logic [DEPTH*ID_W-1:0]     hist;
  logic                      warning;
  logic [1:0]                warn_code;

  always #5 CLK = ~CLK;

  f1_race_tally #(.NUM_CH(NUM_CH), .ID_W(ID_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (clear),
    .valid     (valid),
    .number    (number),
    .mode      (mode),
    .selection (selection),
    .count     (count),
    .total     (total),
    .hist      (hist),
    .warning   (warning),
    .warn_code (warn_code)
  );

  typedef struct packed {
    logic [NUM_CH*COUNT_W-1:0] count;
    logic [COUNT_W+CH_W-1:0]   total;
    logic [DEPTH*ID_W-1:0]     hist;
    logic                      warning;
    logic [1:0]                code;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference state: where[id] is the channel holding the ID, or -1.
  int where[NUM_ID];
  int m_hist[DEPTH];
  int m_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_ID; i++) where[i] = -1;
    for (int s = 0; s < DEPTH; s++) m_hist[s] = 0;
    m_code = 0;
  endfunction

  function automatic int occupancy(input int ch);
    int n = 0;
    for (int i = 0; i < NUM_ID; i++) if (where[i] == ch) n++;
    return n;
  endfunction

  function automatic void model_step(input bit clr, input bit v, input int ch, input int id, input bit sel);
    int  code_now = 0;
    bit  acc = 0;
    if (clr) begin
      model_reset();
      return;
    end
    if (v) begin
      if (ch >= NUM_CH) code_now = 3;
      else if (!sel) begin
        if (where[id] == ch) code_now = 1;
        else if (occupancy(ch) == MAXC) code_now = 3;
        else begin
          where[id] = ch;
          acc = 1;
        end
      end else if (where[id] != ch) code_now = 2;
      else begin
        where[id] = -1;
        acc = 1;
      end
    end
    if (acc) begin
      for (int s = DEPTH - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = id;
    end
`ifdef F1_WARN_STICKY_EN
    if (m_code == 0) m_code = code_now;
`else
    m_code = code_now;
`endif
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    int   t = 0;
    e = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e.count[ch*COUNT_W +: COUNT_W] = COUNT_W'(occupancy(ch));
      t += occupancy(ch);
    end
    e.total = (COUNT_W+CH_W)'(t);
    for (int s = 0; s < DEPTH; s++) e.hist[s*ID_W +: ID_W] = ID_W'(m_hist[s]);
    e.code    = 2'(m_code);
    e.warning = (m_code != 0);
    return e;
  endfunction

  task automatic op(input bit clr, input bit v, input int ch, input int id, input bit sel);
    @(negedge CLK);
    clear     = clr;
    valid     = v;
    mode      = CH_W'(ch);
    number    = ID_W'(id);
    selection = sel;
    model_step(clr, v, ch, id, sel);
    @(posedge CLK);
    #1;
    clear = 1'b0;
    valid = 1'b0;
    exp_q.push_back(model_snapshot());
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_total"}, 32'(total), 32'd0);
    chk({tag, "_hist"}, 32'(hist), 32'd0);
    chk({tag, "_warning"}, 32'(warning), 32'd0);
    chk({tag, "_warn_code"}, 32'(warn_code), 32'd0);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("count", 32'(count), 32'(mon_e.count));
      chk("total", 32'(total), 32'(mon_e.total));
      chk("hist", 32'(hist), 32'(mon_e.hist));
      chk("warning", 32'(warning), 32'(mon_e.warning));
      chk("warn_code", 32'(warn_code), 32'(mon_e.code));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    RST = 1'b1;
    @(posedge CLK);
    #2;
    chk_zero("reset_state");
    @(negedge CLK);
    RST = 1'b0;

    op(0, 1, 0, 3, 0);
    op(0, 1, 1, 5, 0);
    drain();
    // Async reset asserted between edges while an add is being presented.
    @(posedge CLK);
    #3;
    RST       = 1'b1;
    valid     = 1'b1;
    number    = ID_W'(9);
    mode      = '0;
    selection = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge CLK);
    #2;
    chk_zero("rst_hold");
    @(negedge CLK);
    RST   = 1'b0;
    valid = 1'b0;

    op(0, 1, 0, 11, 0);
    op(0, 1, 0, 11, 0);
    op(0, 1, 1, 7, 0);
    op(0, 1, 1, 11, 0);
    op(0, 1, 1, 6, 1);
    op(0, 1, 1, 7, 1);
    op(0, 1, 0, 1, 0);
    op(0, 1, 0, 2, 0);
    op(0, 1, 0, 3, 0);
    op(0, 1, 0, 4, 0);
    op(0, 1, 2, 3, 0);
    op(0, 1, 3, 5, 0);
    op(0, 1, 3, 5, 1);
    op(0, 0, 0, 0, 0);
    op(1, 1, 0, 15, 0);
    op(0, 1, 0, 11, 0);
    op(0, 1, 1, 11, 0);
    op(0, 1, 1, 11, 0);
    op(0, 1, 2, 12, 1);
    op(0, 1, 0, 13, 0);
    op(1, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      op($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
         int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    end

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
